// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one full-adder cell and a carry FF, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_OVERFLOW_EN to build signed-overflow detection; otherwise ovf is tied to 0.
`timescale 1ns/1ps

// state | meaning
// IDLE  | in_ready high, waiting for an operand set
// SHIFT | one operand bit per cycle through the full adder
// DONE  | result valid, waiting for out_ready
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             r_ovf;
`endif

    logic             w_sum;
    logic             w_carry_nxt;
    logic             w_last;
    logic [WIDTH-1:0] w_sr_nxt;

    assign w_sum       = r_sa[0] ^ r_sb[0] ^ r_carry;
    assign w_carry_nxt = (r_sa[0] & r_sb[0]) | (r_carry & (r_sa[0] ^ r_sb[0]));
    assign w_last      = (r_cnt == CW'(WIDTH - 1));
    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at SR[0].
    assign w_sr_nxt    = (r_sr >> 1) | {w_sum, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sa        <= '0;
            r_sb        <= '0;
            r_sr        <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sa       <= in0;
                        r_sb       <= in1 ^ {WIDTH{sub}};
                        r_carry    <= cin ^ sub;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sr    <= w_sr_nxt;
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_carry <= w_carry_nxt;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_out       <= w_sr_nxt;
                        r_cout      <= w_carry_nxt;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        // On the MSB bit, r_carry is the carry into the MSB.
                        r_ovf       <= r_carry ^ w_carry_nxt;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign cout      = r_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign ovf       = r_ovf;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors, backpressure, mid-operation reset, random stream.
`timescale 1ns/1ps

module tb_serial_adder;

    localparam int W = 8;
    localparam int TMO = 64;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] dut_out;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dut_out),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, cout, out} from plain integer arithmetic and operand signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
        logic [W-1:0] bp;
        logic [W:0]   full;
        logic         v;
        bp   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bp} + (W+1)'(c ^ s);
        v    = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
`ifndef SERIAL_ADDER_OVERFLOW_EN
        v    = 1'b0;
`endif
        return {v, full};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in0 = '0; in1 = '0; cin = 1'b0; sub = 1'b0;
        #3;
        checks++;
        if ({in_ready, out_valid, dut_out, cout, ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got rdy=%b vld=%b out=%h cout=%b ovf=%b, expected rdy=1 vld=0 out=0 cout=0 ovf=0",
                     in_ready, out_valid, dut_out, cout, ovf);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{8'h5A, 8'hFF, 8'hFF, 8'h10, 8'h80};
        logic [W-1:0] tb [5] = '{8'h3C, 8'h01, 8'h00, 8'h20, 8'h01};
        logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic         ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W+1:0] exp;
        int n;
        for (int i = 0; i < 5; i++) begin
            exp = model(ta[i], tb[i], tc[i], ts[i]);
            in0 = ta[i]; in1 = tb[i]; cin = tc[i]; sub = ts[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < TMO) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (n != W) begin
                errors++;
                $display("FAIL directed[%0d] latency: got %0d cycles, expected %0d", i, n, W);
            end
            checks++;
            if ({ovf, cout, dut_out} !== exp) begin
                errors++;
                $display("FAIL directed[%0d] result: got ovf=%b cout=%b out=%h, expected ovf=%b cout=%b out=%h",
                         i, ovf, cout, dut_out, exp[W+1], exp[W], exp[W-1:0]);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed[%0d] release: got vld=%b rdy=%b, expected vld=0 rdy=1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W+1:0] exp;
        int n;
        exp = model(8'h5A, 8'h3C, 1'b0, 1'b0);
        in0 = 8'h5A; in1 = 8'h3C; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < TMO) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != W) begin
            errors++;
            $display("FAIL bp latency: got %0d cycles, expected %0d", n, W);
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = ~in_valid;
            in0 = W'($urandom); in1 = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, cout, dut_out} !== exp) begin
                errors++;
                $display("FAIL bp hold[%0d]: got vld=%b rdy=%b ovf=%b cout=%b out=%h, expected vld=1 rdy=0 ovf=%b cout=%b out=%h",
                         k, out_valid, in_ready, ovf, cout, dut_out, exp[W+1], exp[W], exp[W-1:0]);
            end
        end
        exp = model(8'h10, 8'h20, 1'b0, 1'b1);
        in0 = 8'h10; in1 = 8'h20; cin = 1'b0; sub = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp release: got vld=%b rdy=%b, expected vld=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp accept: got rdy=%b, expected rdy=0", in_ready);
        end
        n = 0;
        while (!out_valid && n < TMO) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != W || {ovf, cout, dut_out} !== exp) begin
            errors++;
            $display("FAIL bp next op: got lat=%0d ovf=%b cout=%b out=%h, expected lat=%0d ovf=%b cout=%b out=%h",
                     n, ovf, cout, dut_out, W, exp[W+1], exp[W], exp[W-1:0]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        logic [W+1:0] exp;
        int n;
        in0 = 8'h5A; in1 = 8'h3C; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, dut_out, cout, ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid reset: got rdy=%b vld=%b out=%h cout=%b ovf=%b, expected rdy=1 vld=0 out=0 cout=0 ovf=0",
                     in_ready, out_valid, dut_out, cout, ovf);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp = model(8'h01, 8'h02, 1'b0, 1'b0);
        in0 = 8'h01; in1 = 8'h02; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < TMO) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != W || {ovf, cout, dut_out} !== exp) begin
            errors++;
            $display("FAIL post reset op: got lat=%0d ovf=%b cout=%b out=%h, expected lat=%0d ovf=%b cout=%b out=%h",
                     n, ovf, cout, dut_out, W, exp[W+1], exp[W], exp[W-1:0]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        localparam int N = 200;
        logic [W+1:0] q[$];
        logic [W+1:0] exp;
        int issued = 0;
        int got = 0;
        int cyc = 0;
        in0 = W'($urandom); in1 = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        in_valid = 1'b1;
        while (got < N && cyc < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream extra result: got out=%h with no operand set outstanding, expected none", dut_out);
                end else begin
                    exp = q.pop_front();
                    if ({ovf, cout, dut_out} !== exp) begin
                        errors++;
                        $display("FAIL stream[%0d]: got ovf=%b cout=%b out=%h, expected ovf=%b cout=%b out=%h",
                                 got, ovf, cout, dut_out, exp[W+1], exp[W], exp[W-1:0]);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in0, in1, cin, sub));
                issued++;
            end
            @(posedge clk); #1;
            cyc++;
            in0 = W'($urandom); in1 = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid = (issued < N) && ($urandom_range(0, 4) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (got != N || issued != N || q.size() != 0) begin
            errors++;
            $display("FAIL stream count: got %0d results for %0d issued (%0d pending), expected %0d/%0d/0",
                     got, issued, q.size(), N, N);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
